// File: rtl/addsub_serial_if.sv
// Handshake and operand/result bundle for addsub_serial.
// master drives the request side; slave is the arithmetic unit.
interface addsub_serial_if #(
  parameter int N = 8
);
  logic         start;
  logic         op;
  logic [N-1:0] A_num;
  logic [N-1:0] B_num;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry;
  logic         sign;
  logic         overflow;
  logic         zero;

  // start is a level request, taken on any rising edge where busy==0;
  // done pulses for one cycle and result/flags stay valid until the next final digit.
  modport master (
    output start, op, A_num, B_num,
    input  busy, done, result, carry, sign, overflow, zero
  );

  modport slave (
    input  start, op, A_num, B_num,
    output busy, done, result, carry, sign, overflow, zero
  );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial N-bit add/subtract, W bits per clock with a registered carry.
// Optional unsigned saturation when ADDSUB_SAT_EN is defined; default build wraps modulo 2^N.
module addsub_serial #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_serial_if.slave      bus,
  output logic [1:0]          state_dbg
);

  localparam int DIGITS = N / W;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if ((N < 2) || (W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
    $error("addsub_serial: N must be >= 2 and a multiple of W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  shadow_q;
  logic          op_q;
  logic          cy_q;
  logic [CW-1:0] cnt;

  logic [W:0]    dsum;
  logic [N-1:0]  shadow_next;
  logic [N-1:0]  res_final;
  logic          last;
  logic          ov_raw;

  assign state_dbg = state;

  // Operands shift right each RUN cycle, so the current digit is always in bits [W-1:0];
  // sum digits enter the shadow from the top and reach their final place after N/W cycles.
  always_comb begin
    dsum        = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, cy_q};
    shadow_next = shadow_q >> W;
    shadow_next[N-1 -: W] = dsum[W-1:0];
    last        = (cnt == CW'(DIGITS - 1));
    ov_raw      = (a_q[W-1] == b_q[W-1]) && (dsum[W-1] != a_q[W-1]);
    res_final   = shadow_next;
`ifdef ADDSUB_SAT_EN
    if (!op_q && dsum[W]) begin
      res_final = '1;
    end else if (op_q && !dsum[W]) begin
      res_final = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      shadow_q     <= '0;
      op_q         <= 1'b0;
      cy_q         <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.carry    <= 1'b0;
      bus.sign     <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.A_num;
            b_q      <= bus.op ? ~bus.B_num : bus.B_num;
            op_q     <= bus.op;
            cy_q     <= bus.op;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          a_q      <= a_q >> W;
          b_q      <= b_q >> W;
          cy_q     <= dsum[W];
          shadow_q <= shadow_next;
          cnt      <= cnt + 1'b1;
          if (last) begin
            state        <= DONE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.result   <= res_final;
            bus.carry    <= dsum[W];
            bus.sign     <= op_q & ~dsum[W];
            bus.overflow <= ov_raw;
            bus.zero     <= (res_final == '0);
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: N=8/W=2 vector table and corner sequences,
// plus an N=16/W=16 single-cycle random sweep against a full-width reference.
module tb_addsub_serial;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_serial_if #(.N(8))  bus8 ();
  addsub_serial_if #(.N(16)) bus16 ();
  logic [1:0] st8;
  logic [1:0] st16;

  addsub_serial #(.N(8), .W(2)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus8),
    .state_dbg (st8)
  );

  addsub_serial #(.N(16), .W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus16),
    .state_dbg (st16)
  );

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] res_sat;
    logic       c;
    logic       s;
    logic       v;
    logic       z;
    logic       z_sat;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Request one 8-bit op; returns at the negedge following the accepting edge,
  // with the operand inputs scrambled to show they are no longer looked at.
  task automatic issue8(input logic op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.A_num = a;
    bus8.B_num = b;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.op    = 1'($urandom_range(0, 1));
    bus8.A_num = 8'($urandom_range(0, 255));
    bus8.B_num = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_done8(input int lat0, output int lat, output int nbusy);
    lat   = lat0;
    nbusy = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      if (bus8.busy === 1'b1) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check("done_timeout8", 32'(lat), 32'd4);
  endtask

  vec_t       vecs[10];
  int         lat;
  int         nbusy;
  int         ndone;
  logic [7:0] er;
  logic       ez;
  logic [7:0] popped;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //         op  a      b      res    res_sat c     s     v     z     z_sat
    vecs[0] = '{1'b1, 8'h05, 8'h03, 8'h02, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'hA5, 8'h5A, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 8'h80, 8'h80, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    bus8.start = 1'b0;  bus8.op = 1'b0;  bus8.A_num = '0;  bus8.B_num = '0;
    bus16.start = 1'b0; bus16.op = 1'b0; bus16.A_num = '0; bus16.B_num = '0;

    // Reset state
    #12;
    check("rst_busy",   32'(bus8.busy),     32'd0);
    check("rst_done",   32'(bus8.done),     32'd0);
    check("rst_result", 32'(bus8.result),   32'd0);
    check("rst_flags",  32'({bus8.carry, bus8.sign, bus8.overflow, bus8.zero}), 32'd0);
    check("rst_state",  32'(st8),           32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
`ifdef ADDSUB_SAT_EN
      er = vecs[i].res_sat;
      ez = vecs[i].z_sat;
`else
      er = vecs[i].res;
      ez = vecs[i].z;
`endif
      exp_q.push_back(er);
      issue8(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done8(0, lat, nbusy);
      popped = exp_q.pop_front();
      check($sformatf("v%0d_latency", i), 32'(lat),             32'd4);
      check($sformatf("v%0d_busy_cycles", i), 32'(nbusy),       32'd4);
      check($sformatf("v%0d_result", i),  32'(bus8.result),     32'(popped));
      check($sformatf("v%0d_carry", i),   32'(bus8.carry),      32'(vecs[i].c));
      check($sformatf("v%0d_sign", i),    32'(bus8.sign),       32'(vecs[i].s));
      check($sformatf("v%0d_overflow", i), 32'(bus8.overflow),  32'(vecs[i].v));
      check($sformatf("v%0d_zero", i),    32'(bus8.zero),       32'(ez));
      check($sformatf("v%0d_busy_in_done", i), 32'(bus8.busy),  32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus8.done),    32'd0);
      check($sformatf("v%0d_result_hold", i), 32'(bus8.result), 32'(er));
    end

    // Start during RUN is ignored, then back-to-back start from DONE
    issue8(1'b1, 8'h05, 8'h03);
    @(negedge clk);
    bus8.start = 1'b1; bus8.op = 1'b0; bus8.A_num = 8'hAA; bus8.B_num = 8'h11;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(2, lat, nbusy);
    check("ign_latency", 32'(lat),         32'd4);
    check("ign_result",  32'(bus8.result), 32'h02);
    check("ign_carry",   32'(bus8.carry),  32'd1);
    bus8.start = 1'b1; bus8.op = 1'b0; bus8.A_num = 8'h10; bus8.B_num = 8'h20;
    @(negedge clk);
    bus8.start = 1'b0; bus8.A_num = 8'hFF; bus8.B_num = 8'hFF;
    check("b2b_busy",        32'(bus8.busy),   32'd1);
    check("b2b_done_low",    32'(bus8.done),   32'd0);
    check("b2b_result_held", 32'(bus8.result), 32'h02);
    wait_done8(0, lat, nbusy);
    check("b2b_latency", 32'(lat),         32'd4);
    check("b2b_result",  32'(bus8.result), 32'h30);
    check("b2b_carry",   32'(bus8.carry),  32'd0);

    // Reset in the middle of RUN
    issue8(1'b0, 8'h7F, 8'h01);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(bus8.busy),   32'd0);
    check("mid_rst_done",   32'(bus8.done),   32'd0);
    check("mid_rst_result", 32'(bus8.result), 32'd0);
    check("mid_rst_flags",  32'({bus8.carry, bus8.sign, bus8.overflow, bus8.zero}), 32'd0);
    check("mid_rst_state",  32'(st8),         32'd0);
    ndone = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    issue8(1'b1, 8'h05, 8'h03);
    wait_done8(0, lat, nbusy);
    check("post_rst_latency", 32'(lat),         32'd4);
    check("post_rst_result",  32'(bus8.result), 32'h02);
    check("post_rst_carry",   32'(bus8.carry),  32'd1);

    // N=16, W=16: one RUN cycle per op
    for (int i = 0; i < 24; i++) begin
      logic        op;
      logic [15:0] a, b, bb, r;
      logic        c, s, v, z;
      op = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 65535));
      b  = 16'($urandom_range(0, 65535));
      if (i == 0) begin op = 1'b1; a = 16'h0003; b = 16'h0005; end
      if (i == 1) begin op = 1'b0; a = 16'hFFFF; b = 16'h0001; end
      if (i == 2) begin op = 1'b0; a = 16'h7FFF; b = 16'h0001; end
      bb     = op ? ~b : b;
      {c, r} = {1'b0, a} + {1'b0, bb} + {16'd0, op};
      s      = op & ~c;
      v      = (a[15] == bb[15]) && (r[15] != a[15]);
`ifdef ADDSUB_SAT_EN
      if (!op && c) r = 16'hFFFF;
      else if (op && !c) r = 16'h0000;
`endif
      z = (r == 16'h0000);
      @(negedge clk);
      bus16.start = 1'b1; bus16.op = op; bus16.A_num = a; bus16.B_num = b;
      @(negedge clk);
      bus16.start = 1'b0; bus16.A_num = ~a; bus16.B_num = ~b;
      lat = 0;
      while (bus16.done !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("w16_%0d_latency", i),  32'(lat),            32'd1);
      check($sformatf("w16_%0d_result", i),   32'(bus16.result),   32'(r));
      check($sformatf("w16_%0d_flags", i),
            32'({bus16.carry, bus16.sign, bus16.overflow, bus16.zero}), 32'({c, s, v, z}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
